// File: rtl/ball_motion_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ball_motion_engine
//  Description : Frame-rate square-sprite position engine. Detects the end of
//                each VS pulse, advances the ball once every FRAME_DIV frames
//                with edge reflection, and produces a registered per-pixel
//                ball_hit flag for the downstream colour stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_motion_engine #(
    parameter int VIDEO_W   = 640,
    parameter int VIDEO_H   = 480,
    parameter int BALL_SIZE = 5,
    parameter int STEP_X    = 1,
    parameter int STEP_Y    = 1,
    parameter int FRAME_DIV = 1,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 50
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        VS,
    input  logic        blank_n,
    input  logic [10:0] xPos,
    input  logic [9:0]  yPos,
    input  logic        enable,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic        bounce,
    output logic        ball_hit
);

    localparam int          FC_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [11:0] MAX_X     = 12'(VIDEO_W - BALL_SIZE);
    localparam logic [11:0] MAX_Y     = 12'(VIDEO_H - BALL_SIZE);
    localparam logic [11:0] STEP_X12  = 12'(STEP_X);
    localparam logic [11:0] STEP_Y12  = 12'(STEP_Y);
    localparam logic [11:0] SIZE12    = 12'(BALL_SIZE);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        MOVE_X = 2'd1,
        MOVE_Y = 2'd2
    } state_t;

    state_t          state;
    logic            vs_d;
    logic [FC_W-1:0] frame_cnt;

    logic            tick;
    logic            div_done;
    logic            step_start;
    logic [11:0]     x_ext;
    logic [11:0]     y_ext;
    logic [11:0]     x_fwd;
    logic [11:0]     y_fwd;
    logic [11:0]     x_back;
    logic [11:0]     y_back;
    logic            hit_next;

    // Frame tick, divider terminal count and 12-bit candidate positions
    always_comb begin
        tick       = VS & ~vs_d;
        div_done   = (frame_cnt == FC_LAST);
        step_start = tick & enable & div_done;
        x_ext      = {1'b0, ball_x};
        y_ext      = {2'b00, ball_y};
        x_fwd      = x_ext + STEP_X12;
        y_fwd      = y_ext + STEP_Y12;
        x_back     = x_ext - STEP_X12;
        y_back     = y_ext - STEP_Y12;
        hit_next   = blank_n
                   & ({1'b0, xPos}   >= x_ext) & ({1'b0, xPos}   < x_ext + SIZE12)
                   & ({2'b00, yPos}  >= y_ext) & ({2'b00, yPos}  < y_ext + SIZE12);
    end

    // VS edge history, frame divider and the WAIT/MOVE_X/MOVE_Y step sequencer
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vs_d      <= 1'b1;
            frame_cnt <= '0;
            state     <= WAIT;
            ball_x    <= 11'(INIT_X);
            ball_y    <= 10'(INIT_Y);
            dir_x     <= 1'b0;
            dir_y     <= 1'b0;
            bounce    <= 1'b0;
        end else begin
            vs_d   <= VS;
            bounce <= 1'b0;
            if (tick && enable) begin
                frame_cnt <= div_done ? '0 : frame_cnt + 1'b1;
            end
            case (state)
                WAIT: begin
                    // Only a WAIT-state tick can launch a step
                    if (step_start) begin
                        state <= MOVE_X;
                    end
                end
                MOVE_X: begin
                    if (!dir_x) begin
                        if (x_fwd >= MAX_X) begin
                            ball_x <= MAX_X[10:0];
                            dir_x  <= 1'b1;
                            bounce <= 1'b1;
                        end else begin
                            ball_x <= x_fwd[10:0];
                        end
                    end else begin
                        if (x_ext <= STEP_X12) begin
                            ball_x <= '0;
                            dir_x  <= 1'b0;
                            bounce <= 1'b1;
                        end else begin
                            ball_x <= x_back[10:0];
                        end
                    end
                    state <= MOVE_Y;
                end
                MOVE_Y: begin
                    if (!dir_y) begin
                        if (y_fwd >= MAX_Y) begin
                            ball_y <= MAX_Y[9:0];
                            dir_y  <= 1'b1;
                            bounce <= 1'b1;
                        end else begin
                            ball_y <= y_fwd[9:0];
                        end
                    end else begin
                        if (y_ext <= STEP_Y12) begin
                            ball_y <= '0;
                            dir_y  <= 1'b0;
                            bounce <= 1'b1;
                        end else begin
                            ball_y <= y_back[9:0];
                        end
                    end
                    state <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

    // Registered per-pixel hit flag, gated by the visible-area qualifier
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            ball_hit <= 1'b0;
        end else begin
            ball_hit <= hit_next;
        end
    end

endmodule
`default_nettype wire
